// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the six-digit seven-segment scan driver.
package seg7_scan_driver_pkg;

  // Mode word from the clock controller; any other code is treated as invalid.
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_SET   = 4'd1,
    S_START = 4'd3
  } mode_e;

  // Digit identity codes (identity = slot + 1).
  localparam logic [3:0] DIG_LSB = 4'd1;
  localparam logic [3:0] DIG_HSB = 4'd2;
  localparam logic [3:0] DIG_LMB = 4'd3;
  localparam logic [3:0] DIG_HMB = 4'd4;
  localparam logic [3:0] DIG_LHB = 4'd5;
  localparam logic [3:0] DIG_HHB = 4'd6;

  localparam int unsigned NumDigits = 6;

  // Active-low segment words, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // BCD to active-low pattern; non-decimal codes show a dash.
  function automatic logic [6:0] seg_pattern(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup lives in the package so every user shares one encoding.
  always_comb begin
    seg_o = seg_pattern(bcd_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed six-digit seven-segment driver with set-mode blink,
// colon dots and leading-zero blanking. Outputs are registered.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic [23:0] currentBits,
  input  logic [3:0]  editDigit,
  input  logic        blankLead,
  output logic [5:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]        slot_q, slot_d;
  logic              phase_q, phase_d;
  logic [23:0]       frame_q, frame_d;
  logic [5:0]        anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic        scan_wrap, blink_wrap;
  logic [3:0]  digit;
  logic [6:0]  digit_seg;
  logic        mode_valid, lead_blank, edit_hit;

  // Counter, slot, blink phase and frame next-state.
  always_comb begin
    scan_wrap   = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    blink_wrap  = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = blink_wrap ? ~phase_q : phase_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    if (scan_wrap) begin
      slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
      // Latch a whole frame only as the scan returns to slot 0 so digits never tear.
      if (slot_q == 3'd5) frame_d = currentBits;
    end
  end

  // Select the nibble for the slot being driven.
  always_comb begin
    digit = frame_q[3:0];
    case (slot_q)
      3'd1:    digit = frame_q[7:4];
      3'd2:    digit = frame_q[11:8];
      3'd3:    digit = frame_q[15:12];
      3'd4:    digit = frame_q[19:16];
      3'd5:    digit = frame_q[23:20];
      default: digit = frame_q[3:0];
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd_i (digit),
    .seg_o (digit_seg)
  );

  // Output decode: dark modes, leading-zero blank, edit blink and separators.
  always_comb begin
    mode_valid = (state == S_SET) || (state == S_START);
    lead_blank = blankLead && (slot_q == 3'd5) && (digit == 4'd0);
    // editDigit of 0 or above 6 never equals slot + 1, so nothing blinks.
    edit_hit   = (state == S_SET) && (editDigit == ({1'b0, slot_q} + 4'd1));
    anode_d    = 6'h3F;
    if (mode_valid && !lead_blank && !(edit_hit && !phase_q)) begin
      anode_d = ~(6'b000001 << slot_q);
    end
    seg_d = mode_valid ? digit_seg : SEG_OFF;
    dp_d  = 1'b1;
    if (((slot_q == 3'd2) || (slot_q == 3'd4)) &&
        ((state == S_SET) || ((state == S_START) && phase_q))) begin
      dp_d = 1'b0;
    end
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      slot_q      <= 3'd0;
      phase_q     <= 1'b1;
      frame_q     <= '0;
      anode_q     <= 6'h3F;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: driver pushes expected outputs,
// a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int BD = 16;
  localparam int FRAME = 6 * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic [23:0] currentBits;
  logic [3:0]  editDigit;
  logic        blankLead;
  logic [5:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [5:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       chk_seg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: time since reset plus the last latched frame.
  int unsigned mdl_n = 0;
  logic [23:0] mdl_frame = '0;

  seg7_scan_driver #(
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .currentBits (currentBits),
    .editDigit   (editDigit),
    .blankLead   (blankLead),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  // Conventional active-high gfedcba digits; the display wants the inverse.
  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] hi;
    case (d)
      0: hi = 7'h3F; 1: hi = 7'h06; 2: hi = 7'h5B; 3: hi = 7'h4F; 4: hi = 7'h66;
      5: hi = 7'h6D; 6: hi = 7'h7D; 7: hi = 7'h07; 8: hi = 7'h7F; 9: hi = 7'h6F;
      default: hi = 7'h40;
    endcase
    return ~hi;
  endfunction

  function automatic int cur_slot();
    return (mdl_n / SD) % 6;
  endfunction

  // Predict the outputs produced by the coming edge, then advance the model.
  task automatic predict();
    exp_t e;
    int slot, d;
    bit phase, valid, blank;
    if (!rst_n) begin
      e = '{anode: 6'h3F, seg: 7'h7F, dp: 1'b1, chk_seg: 1'b1};
      mdl_n = 0;
      mdl_frame = '0;
    end else begin
      slot  = cur_slot();
      phase = ((mdl_n / BD) % 2) == 0;
      d     = int'((mdl_frame >> (4 * slot)) & 24'hF);
      valid = (state == 4'd1) || (state == 4'd3);
      blank = !valid || (blankLead && slot == 5 && d == 0) ||
              (state == 4'd1 && int'(editDigit) == slot + 1 && !phase);
      e.anode   = blank ? 6'h3F : ~(6'(1) << slot);
      e.seg     = ref_seg(d);
      e.chk_seg = !blank;
      e.dp      = !((slot == 2 || slot == 4) &&
                    (state == 4'd1 || (state == 4'd3 && phase)));
      mdl_n++;
      if (mdl_n % FRAME == 0) mdl_frame = currentBits;
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      predict();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_until_slot(input int s);
    for (int i = 0; i < FRAME && cur_slot() != s; i++) step(1);
  endtask

  task automatic step_until_frame();
    for (int i = 0; i < FRAME && (mdl_n % FRAME) != 0; i++) step(1);
  endtask

  // Monitor: one comparison per clock once expectations exist.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (anode !== e.anode || dp !== e.dp || (e.chk_seg && seg !== e.seg)) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t: anode=%h dp=%b seg=%b, required anode=%h dp=%b seg=%b%s",
                   vectors, $time, anode, dp, seg, e.anode, e.dp, e.seg,
                   e.chk_seg ? "" : " (seg unchecked)");
        end
      end
    end
  end

  initial begin
    int r;
    rst_n = 1'b0; state = 4'd3; currentBits = 24'h0; editDigit = 4'd0; blankLead = 1'b0;
    #1;
    // Reset hold, then run with the HH:MM:SS example.
    step(3);
    rst_n = 1'b1; currentBits = 24'h235959;
    step(3 * FRAME);
    // Tearing: new value arrives mid-frame.
    currentBits = 24'h000000;
    step(FRAME);
    step_until_frame();
    step_until_slot(2);
    currentBits = 24'h111111;
    step(2 * FRAME);
    // Set-mode blink of identity 3.
    state = 4'd1; editDigit = 4'd3; currentBits = 24'h120000;
    step(4 * FRAME);
    editDigit = 4'd0;
    step(FRAME);
    editDigit = 4'd7;
    step(FRAME);
    // Dash, leading-zero blank, invalid mode.
    state = 4'd3; editDigit = 4'd0; currentBits = 24'h00000B;
    step(2 * FRAME);
    blankLead = 1'b1; currentBits = 24'h012345;
    step(2 * FRAME);
    state = 4'd2;
    step(FRAME);
    state = 4'd0;
    step(FRAME);
    // Reset mid-frame at slot 3.
    state = 4'd3; blankLead = 1'b0; currentBits = 24'h987654;
    step(FRAME);
    step_until_slot(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2 * FRAME);
    // Randomised segments of stimulus.
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) state = 4'd3;
      else if (r < 7) state = 4'd1;
      else if (r < 8) state = 4'd0;
      else state = 4'($urandom_range(2, 15));
      currentBits = 24'($urandom);
      if ($urandom_range(0, 3) == 0) currentBits[23:20] = 4'd0;
      editDigit = 4'($urandom_range(0, 7));
      blankLead = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 19) != 0);
      step(1);
      rst_n = 1'b1;
      step($urandom_range(1, 30));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
